// File: rtl/mem_burst_master.sv
// Burst initiator for a 1K x 19 synchronous single-port RAM: turns valid/ready burst
// commands into per-cycle we/addr/wdata and buffers the registered read returns.
module mem_burst_master #(
    parameter int DATA_W   = 19,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 10,
    parameter int RD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int PTR_W = $clog2(RD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_e;
    state_e state_q, state_d;

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W:0]    beats_q, beats_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              iss_p0_q, iss_p0_d;
    logic              iss_p1_q, iss_p1_d;

    logic [DATA_W-1:0] rbuf_q [RD_DEPTH];
    logic [PTR_W-1:0]  rwp_q, rwp_d;
    logic [PTR_W-1:0]  rrp_q, rrp_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;

    logic              cmd_hs, wr_hs, rd_pop, rd_push, rd_issue, rd_room, rd_drained;
    logic [CNT_W:0]    inflight;

    assign cmd_hs  = cmd_valid & cmd_ready;
    assign wr_hs   = wr_valid & wr_ready;
    assign rd_pop  = rd_valid & rd_ready;
    // A read issued at edge e is presented by the RAM after e+1 and captured at e+2.
    assign rd_push = iss_p1_q;

    assign inflight   = {1'b0, rcnt_q} + {{CNT_W{1'b0}}, iss_p0_q} + {{CNT_W{1'b0}}, iss_p1_q};
    assign rd_room    = inflight < (CNT_W+1)'(RD_DEPTH);
    assign rd_drained = (beats_q == '0) && !iss_p0_q && !iss_p1_q &&
                        ((rcnt_q == '0) || ((rcnt_q == CNT_W'(1)) && rd_pop));

    assign rd_valid  = (rcnt_q != '0);
    assign rd_data   = rd_valid ? rbuf_q[rrp_q] : '0;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_hs) state_d = cmd_write ? WRITE : READ;
            WRITE:   if (wr_hs && (beats_q == (LEN_W+1)'(1))) state_d = IDLE;
            READ:    if (rd_drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        busy      = 1'b1;
        rd_issue  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            WRITE:   wr_ready = 1'b1;
            READ:    rd_issue = (beats_q != '0) && rd_room;
            default: ;
        endcase
    end

    // Pointer, beat counter and RAM-side registers.
    always_comb begin
        ptr_d    = ptr_q;
        beats_d  = beats_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        iss_p0_d = 1'b0;
        iss_p1_d = iss_p0_q;
        if (cmd_hs) begin
            if (cmd_write) begin
                ptr_d   = cmd_addr;
                beats_d = {1'b0, cmd_len} + (LEN_W+1)'(1);
            end else begin
                // The first read goes out on the handshake edge itself.
                addr_d   = cmd_addr;
                iss_p0_d = 1'b1;
                ptr_d    = cmd_addr + ADDR_W'(1);
                beats_d  = {1'b0, cmd_len};
            end
        end else if (wr_hs) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = wr_data;
            ptr_d   = ptr_q + ADDR_W'(1);
            beats_d = beats_q - (LEN_W+1)'(1);
        end else if (rd_issue) begin
            addr_d   = ptr_q;
            iss_p0_d = 1'b1;
            ptr_d    = ptr_q + ADDR_W'(1);
            beats_d  = beats_q - (LEN_W+1)'(1);
        end
    end

    always_comb begin
        rwp_d  = rd_push ? rwp_q + PTR_W'(1) : rwp_q;
        rrp_d  = rd_pop  ? rrp_q + PTR_W'(1) : rrp_q;
        rcnt_d = rcnt_q;
        unique case ({rd_push, rd_pop})
            2'b10:   rcnt_d = rcnt_q + CNT_W'(1);
            2'b01:   rcnt_d = rcnt_q - CNT_W'(1);
            default: rcnt_d = rcnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            beats_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            iss_p0_q <= 1'b0;
            iss_p1_q <= 1'b0;
            rwp_q    <= '0;
            rrp_q    <= '0;
            rcnt_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            beats_q  <= beats_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            iss_p0_q <= iss_p0_d;
            iss_p1_q <= iss_p1_d;
            rwp_q    <= rwp_d;
            rrp_q    <= rrp_d;
            rcnt_q   <= rcnt_d;
        end
    end

    // Buffer storage carries no reset; rd_data is gated by rd_valid instead.
    always_ff @(posedge clk) begin
        if (rd_push) rbuf_q[rwp_q] <= mem_rdata;
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural read-first 1K x 19 RAM attached.
module tb_mem_burst_master;
    localparam int DATA_W = 19;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              wr_valid = 1'b0, wr_ready;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_valid, rd_ready = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy;

    logic [DATA_W-1:0] ram [1024];

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] wrap_d [4] = '{19'h7FFFF, 19'h00001, 19'h00002, 19'h00003};
    logic [ADDR_W-1:0] wrap_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

    int                issued, popped, occ, max_occ, got;
    logic [DATA_W-1:0] got_data [8];
    logic              stalled;
    logic [DATA_W-1:0] held;
    logic [ADDR_W-1:0] prev_addr;
    logic [6:0]        gap_pat = 7'b1011001;
    int                landed;
    logic              exp_we;

    mem_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        for (int k = 0; k < 60 && busy; k++) tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h005; cmd_len = '0;
        repeat (3) tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0h exp 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0h exp 0", mem_we); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0h exp 0", rd_valid); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %0h exp 0", wr_ready); end
        checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL reset_mem_addr got %0h exp 0", mem_addr); end
        checks++; if (rd_data !== 19'h0) begin errors++; $display("FAIL reset_rd_data got %0h exp 0", rd_data); end
        rst_n = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL release_accept busy got %0h exp 1", busy); end
        checks++; if (mem_addr !== 10'h005) begin errors++; $display("FAIL release_addr got %0h exp 005", mem_addr); end
        rd_ready = 1'b1;
        wait_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_idle_timeout busy got %0h exp 0", busy); end
        rd_ready = 1'b0;
    endtask

    task automatic test_write_wrap;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h3FE; cmd_len = 10'd3;
        wr_valid = 1'b1; wr_data = wrap_d[0];
        tick();
        cmd_valid = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL same_cycle_wr_taken mem_we got %0h exp 0", mem_we); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL write_wr_ready got %0h exp 1", wr_ready); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL write_cmd_ready got %0h exp 0", cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            wr_data = wrap_d[i]; wr_valid = 1'b1;
            tick();
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wrap_we[%0d] got %0h exp 1", i, mem_we); end
            checks++; if (mem_addr !== wrap_a[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %0h exp %0h", i, mem_addr, wrap_a[i]); end
            checks++; if (mem_wdata !== wrap_d[i]) begin errors++; $display("FAIL wrap_wdata[%0d] got %0h exp %0h", i, mem_wdata, wrap_d[i]); end
        end
        wr_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_end_busy got %0h exp 0", busy); end
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wrap_we_pulse got %0h exp 0", mem_we); end
    endtask

    task automatic test_read_wrap;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h3FE; cmd_len = 10'd3; rd_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if (mem_addr !== 10'h3FE) begin errors++; $display("FAIL rd_first_addr got %0h exp 3fe", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we got %0h exp 0", mem_we); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_early_n1 got %0h exp 0", rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_early_n2 got %0h exp 0", rd_valid); end
        checks++; if (mem_addr !== 10'h3FF) begin errors++; $display("FAIL rd_second_addr got %0h exp 3ff", mem_addr); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_wrap_valid[%0d] got %0h exp 1", i, rd_valid); end
            checks++; if (rd_data !== wrap_d[i]) begin errors++; $display("FAIL rd_wrap_data[%0d] got %0h exp %0h", i, rd_data, wrap_d[i]); end
        end
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_wrap_tail_valid got %0h exp 0", rd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_wrap_idle got %0h exp 0", busy); end
        rd_ready = 1'b0;
    endtask

    task automatic test_read_backpressure;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h010; cmd_len = 10'd7;
        tick();
        cmd_valid = 1'b0; wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = DATA_W'(32'h100 + i);
            tick();
        end
        wr_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_fill_idle got %0h exp 0", busy); end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h010; cmd_len = 10'd7; rd_ready = 1'b0;
        prev_addr = mem_addr;
        issued = 0; popped = 0; max_occ = 0; got = 0; stalled = 1'b0; held = '0;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 200 && got < 8; c++) begin
            if (mem_addr != prev_addr) issued++;
            prev_addr = mem_addr;
            occ = issued - popped;
            if (occ > max_occ) max_occ = occ;
            if (stalled) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== held) begin
                    errors++; $display("FAIL bp_stall_hold got %0h/%0h exp 1/%0h", rd_valid, rd_data, held);
                end
            end
            rd_ready = ((c % 3) == 0);
            if (rd_valid && rd_ready) begin
                got_data[got] = rd_data; got++; popped++; stalled = 1'b0;
            end else if (rd_valid) begin
                stalled = 1'b1; held = rd_data;
            end else begin
                stalled = 1'b0;
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (got != 8) begin errors++; $display("FAIL bp_beat_count got %0d exp 8", got); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i < got && got_data[i] !== DATA_W'(32'h100 + i)) begin
                errors++; $display("FAIL bp_order[%0d] got %0h exp %0h", i, got_data[i], 32'h100 + i);
            end
        end
        checks++; if (issued != 8) begin errors++; $display("FAIL bp_issue_count got %0d exp 8", issued); end
        checks++; if (max_occ > 4) begin errors++; $display("FAIL bp_occupancy got %0d exp <=4", max_occ); end
        wait_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_timeout got %0h exp 0", busy); end
    endtask

    task automatic test_write_gaps;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h020; cmd_len = 10'd3;
        tick();
        cmd_valid = 1'b0; landed = 0;
        for (int c = 0; c < 8; c++) begin
            exp_we = (c > 0) && gap_pat[c-1];
            checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL gap_we[%0d] got %0h exp %0h", c, mem_we, exp_we); end
            if (exp_we) begin
                checks++;
                if (mem_addr !== ADDR_W'(32'h20 + landed) || mem_wdata !== DATA_W'(32'h40 + c - 1)) begin
                    errors++; $display("FAIL gap_beat[%0d] got %0h/%0h exp %0h/%0h", c, mem_addr, mem_wdata, 32'h20 + landed, 32'h40 + c - 1);
                end
                landed++;
            end
            if (c < 7) begin
                wr_valid = gap_pat[c]; wr_data = DATA_W'(32'h40 + c);
                tick();
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_end_idle got %0h exp 0", busy); end
        // Read-after-write right behind the final beat, with a stray wr_valid in IDLE
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h023; cmd_len = 10'd0;
        wr_valid = 1'b1; wr_data = 19'h1ABCD; rd_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 10'h023) begin errors++; $display("FAIL raw_issue got %0h/%0h exp 0/023", mem_we, mem_addr); end
        tick();
        checks++; if (mem_we !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL raw_n2 got %0h/%0h exp 0/0", mem_we, rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 19'h00046) begin errors++; $display("FAIL raw_data got %0h/%0h exp 1/46", rd_valid, rd_data); end
        tick();
        checks++; if (busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL raw_end got %0h/%0h exp 0/0", busy, mem_we); end
        wr_valid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic test_reset_abort;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h010; cmd_len = 10'd7; rd_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 19'h00100) begin errors++; $display("FAIL abort_beat0 got %0h/%0h exp 1/100", rd_valid, rd_data); end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 19'h00101) begin errors++; $display("FAIL abort_beat1 got %0h/%0h exp 1/101", rd_valid, rd_data); end
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL abort_rd_valid got %0h exp 0", rd_valid); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_idle got %0h/%0h exp 0/1", busy, cmd_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet got %0h/%0h/%0h exp 0/0/0", mem_we, rd_valid, busy); end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h030; cmd_len = 10'd0;
        wr_valid = 1'b1; wr_data = 19'h5A5A5; rd_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        wr_valid = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 10'h030 || mem_wdata !== 19'h5A5A5) begin
            errors++; $display("FAIL post_write got %0h/%0h/%0h exp 1/030/5a5a5", mem_we, mem_addr, mem_wdata);
        end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h030; cmd_len = 10'd0; rd_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 19'h5A5A5) begin errors++; $display("FAIL post_read got %0h/%0h exp 1/5a5a5", rd_valid, rd_data); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_idle got %0h exp 0", busy); end
        rd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_wrap();
        test_read_wrap();
        test_read_backpressure();
        test_write_gaps();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
